// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Owns the instruction memory address/write ports. Out of reset it is in
//   LOAD mode: it streams loader words into consecutive memory words. When the
//   loader marks the last word, or the memory fills, it enters RUN mode. In RUN
//   mode it drives the program counter for the IF stage, and it arbitrates the
//   reload, redirect and stall requests.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   ld_valid/ld_data/     streaming loader word, its valid, and the
//   ld_last/ld_ready      last-word marker; ld_ready is high in LOAD mode
//   mem_we/mem_addr/      instruction memory write enable, byte address
//   mem_wdata             and write data
//   stall, redirect,      hazard hold; branch/jump redirect and its target;
//   redirect_pc, reload   request to re-enter load mode
//   pc, fetch_valid       current fetch byte address; instruction at pc valid
//   load_count            words written by the current or last load
module imem_fetch_ctrl #(
  parameter int N = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        reload,
  output logic [15:0] pc,
  output logic        fetch_valid,
  output logic [15:0] load_count
);

  localparam int AW = $clog2(N);
  localparam logic [0:0]    S_LOAD   = 1'b0;
  localparam logic [0:0]    S_RUN    = 1'b1;
  // The byte range is 2N. The mask clears bit 0, and it also wraps the
  // address into that range.
  localparam logic [15:0]   PC_MASK  = 16'(2 * N - 2);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [15:0]   CNT_MAX  = 16'(N);

  logic [0:0]    r_state;
  logic [15:0]   r_pc;
  logic [AW-1:0] r_wr_idx;
  logic [15:0]   r_load_count;

  logic          w_load;
  logic          w_accept;
  logic          w_final;
  logic [15:0]   w_ld_addr;

  assign w_load    = (r_state == S_LOAD);
  // A reload in the same cycle suppresses the write, so the restarted load
  // begins cleanly at word 0.
  assign w_accept  = w_load & ld_valid & ~reload;
  assign w_final   = ld_last | (r_wr_idx == LAST_IDX);
  assign w_ld_addr = 16'({r_wr_idx, 1'b0});

  assign ld_ready    = w_load;
  assign mem_we      = w_accept;
  assign mem_addr    = w_load ? w_ld_addr : r_pc;
  assign mem_wdata   = ld_data;
  assign pc          = r_pc;
  assign fetch_valid = ~w_load;
  assign load_count  = r_load_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_LOAD;
      r_pc         <= '0;
      r_wr_idx     <= '0;
      r_load_count <= '0;
    end else if (w_load) begin
      if (reload) begin
        r_wr_idx     <= '0;
        r_load_count <= '0;
      end else if (ld_valid) begin
        if (r_load_count < CNT_MAX) r_load_count <= r_load_count + 16'd1;
        if (w_final) begin
          r_state  <= S_RUN;
          r_pc     <= '0;
          r_wr_idx <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + AW'(1);
        end
      end
    end else begin
      // A redirect comes before a stall, so a taken target is never lost.
      if (reload) begin
        r_state      <= S_LOAD;
        r_pc         <= '0;
        r_wr_idx     <= '0;
        r_load_count <= '0;
      end else if (redirect) begin
        r_pc <= redirect_pc & PC_MASK;
      end else if (!stall) begin
        r_pc <= (r_pc + 16'd2) & PC_MASK;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0, ld_last = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_ready, mem_we, fetch_valid;
  logic [15:0] mem_addr, mem_wdata, pc, load_count;
  logic        stall = 1'b0, redirect = 1'b0, reload = 1'b0;
  logic [15:0] redirect_pc = '0;

  imem_fetch_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .reload(reload),
    .pc(pc), .fetch_valid(fetch_valid), .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Instruction memory driven by the DUT's write port.
  logic [15:0] imem [N];

  // Reference model: mode, fetch address, next load slot, word count, program.
  int          m_run, m_pc, m_idx, m_cnt;
  logic [15:0] m_prog [N];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 0; m_idx = 0; m_cnt = 0;
  endtask

  // One clock cycle: drive the inputs at the falling edge, compare every
  // output against the model, then advance the model and memory at the
  // rising edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic last,
                     input logic st, input logic rd, input logic [15:0] rpc,
                     input logic rl);
    logic        we_s;
    logic [15:0] a_s, d_s;
    @(negedge clk);
    ld_valid = v; ld_data = d; ld_last = last;
    stall = st; redirect = rd; redirect_pc = rpc; reload = rl;
    #1;
    chk("ld_ready",    ld_ready,    m_run ? 0 : 1);
    chk("fetch_valid", fetch_valid, m_run ? 1 : 0);
    chk("mem_we",      mem_we,      (!m_run && v && !rl) ? 1 : 0);
    chk("mem_addr",    mem_addr,    m_run ? m_pc : 2 * m_idx);
    chk("mem_wdata",   mem_wdata,   d);
    chk("pc",          pc,          m_pc);
    chk("load_count",  load_count,  m_cnt);
    if (m_run) chk("fetch_instr", imem[m_pc / 2], m_prog[m_pc / 2]);
    we_s = mem_we; a_s = mem_addr; d_s = mem_wdata;
    @(posedge clk);
    if (we_s) imem[a_s[15:1] % N] = d_s;
    if (!m_run) begin
      if (rl) begin
        m_idx = 0; m_cnt = 0;
      end else if (v) begin
        m_prog[m_idx] = d;
        m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
        if (last || m_idx == N - 1) begin
          m_run = 1; m_pc = 0; m_idx = 0;
        end else m_idx++;
      end
    end else begin
      if (rl) begin
        m_run = 0; m_pc = 0; m_idx = 0; m_cnt = 0;
      end else if (rd) m_pc = (int'(rpc) % (2 * N)) & ~1;
      else if (!st) m_pc = (m_pc + 2) % (2 * N);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 0, 0, 16'h0, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin imem[i] = '0; m_prog[i] = '0; end
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_mem_we", mem_we, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 4-word load with ld_last on the final word
    cyc(1, 16'h1010, 0, 0, 0, 0, 0);
    cyc(1, 16'h1231, 0, 0, 0, 0, 0);
    cyc(1, 16'h145E, 0, 0, 0, 0, 0);
    cyc(1, 16'h167F, 1, 0, 0, 0, 0);
    #2;
    chk("pin_load_count4", load_count, 16'd4);
    chk("pin_first_run_fv", fetch_valid, 1);
    chk("pin_first_run_pc", pc, 16'h0000);
    chk("pin_word3", imem[3], 16'h167F);
    chk("pin_word1", imem[1], 16'h1231);
    idle(2);
    #2 chk("pin_pc_step", pc, 16'h0004);

    // stall for 3 cycles at pc 4, then resume
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    #2 chk("pin_stall_hold", pc, 16'h0004);
    idle(1);
    #2 chk("pin_stall_resume", pc, 16'h0006);

    // redirect wins over stall; out-of-range target is masked
    cyc(0, 0, 0, 1, 1, 16'h000A, 0);
    #2 chk("pin_redirect_stall", pc, 16'h000A);
    cyc(0, 0, 0, 0, 1, 16'h0025, 0);
    #2 chk("pin_redirect_mask", pc, 16'h0004);
    cyc(0, 0, 0, 0, 1, 16'h0008, 0);

    // reload at pc 8, then a new 2-word load
    cyc(0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("pin_reload_ready", ld_ready, 1);
    chk("pin_reload_fv", fetch_valid, 0);
    chk("pin_reload_pc", pc, 0);
    chk("pin_reload_cnt", load_count, 0);
    cyc(1, 16'hAAAA, 0, 0, 0, 0, 0);
    cyc(1, 16'hBBBB, 1, 0, 0, 0, 0);
    idle(3);
    #2 chk("pin_reload_word1", imem[1], 16'hBBBB);

    // full N-word load with no ld_last, then an extra word to be dropped
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) cyc(1, 16'h2000 + 16'(i), 0, 0, 0, 0, 0);
    #2;
    chk("pin_full_cnt", load_count, 16'(N));
    chk("pin_full_word15", imem[N - 1], 16'h200F);
    cyc(1, 16'hDEAD, 0, 0, 0, 0, 0);
    idle(N - 1);
    #2 chk("pin_wrap_pc", pc, 16'h0000);
    chk("pin_no_extra_write", imem[0], 16'h2000);

    // reload that coincides with a word in LOAD must not write it
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 16'h3000, 0, 0, 0, 0, 0);
    cyc(1, 16'hEEEE, 0, 0, 0, 0, 1);
    #2 chk("pin_reload_in_load", load_count, 0);

    // async reset mid-load after 3 words
    cyc(1, 16'h4000, 0, 0, 0, 0, 0);
    cyc(1, 16'h4001, 0, 0, 0, 0, 0);
    cyc(1, 16'h4002, 0, 0, 0, 0, 0);
    ld_valid = 0; ld_last = 0; reload = 0; stall = 0; redirect = 0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cnt", load_count, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_ready", ld_ready, 1);
    chk("mid_rst_we", mem_we, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 16'h5000, 0, 0, 0, 0, 0);
    #2 chk("pin_after_rst_word0", imem[0], 16'h5000);
    cyc(1, 16'h5001, 1, 0, 0, 0, 0);

    // randomized traffic checked against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          16'($urandom),
          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
          16'($urandom),
          ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
